xtea_port_responder: RTL and testbench
======================================

XTEA_PORT_RESPONDER -- requirements
Module: xtea_port_responder

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'h30; base port address, with register offsets +0 key, +1 data, +3 ctrl, +4 status, +5 result, +6 ptr_clr.
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port port_id  input  8  controller port address.
REQ-005 SHALL have port out_port  input  8  controller write data.
REQ-006 SHALL have port write_strobe  input  1  one-cycle write qualifier.
REQ-007 SHALL have port read_strobe  input  1  one-cycle read qualifier.
REQ-008 SHALL have port in_port  output  8  read data, combinational from port_id.
REQ-009 SHALL have port interrupt  output  1  completion interrupt, level.
REQ-010 SHALL have port interrupt_ack  input  1  one-cycle interrupt acknowledge.

Function
REQ-011 SHALL hold key_reg[127:0], data_reg[63:0] and result_reg[63:0], with pointers kp (4 bit), dp (3 bit) and rp (3 bit).
REQ-012 SHALL, on write to +0 when not busy, load key_reg[8*kp+:8] and increment kp (15 wraps to 0).
REQ-013 SHALL, on write to +1 when not busy, load data_reg[8*dp+:8] and increment dp (7 wraps to 0).
REQ-014 SHALL treat a +0 or +1 write while busy as a no-op: register and pointer unchanged, err set.
REQ-015 SHALL decode ctrl bits: bit0 start, bit1 mode (0 encrypt, 1 decrypt), bit2 irq_en; bits 1 and 2 are latched on every ctrl write accepted in IDLE or DONE.
REQ-016 SHALL run FSM IDLE -> START -> RUN -> DONE; from DONE, a start returns it to START.
REQ-017 SHALL, on ctrl write with bit0=1 in IDLE or DONE: enter START, clear done, clear rp.
REQ-018 SHALL, on ctrl write with bit0=1 in START or RUN: ignore the write and set err.
REQ-019 SHALL, in START, drive core start high for exactly one cycle, then enter RUN; core ready is ignored in START.
REQ-020 SHALL, in RUN, on core ready=1: capture core data_out into result_reg, enter DONE, set done, and set irq_pending if irq_en.
REQ-021 SHALL define busy = (state is START or RUN).
REQ-022 SHALL return status read data {4'b0, err, irq_pending, busy, done}.
REQ-023 SHALL clear err on a read_strobe at +4.
REQ-024 SHALL return result_reg[8*rp+:8] as +5 read data and increment rp on each read_strobe at +5 (7 wraps to 0).
REQ-025 SHALL return 8'h00 on in_port for unmapped port_id; writes to unmapped ports SHALL have no effect.
REQ-026 SHALL, on write to +6: clear kp, dp, rp and err; state, data and result unchanged.
REQ-027 SHALL drive interrupt = irq_pending; interrupt_ack clears it.
REQ-028 SHALL give set priority when interrupt_ack coincides with a new completion: irq_pending stays 1.
REQ-029 SHALL give set priority when a status read coincides with a new err event: err stays 1.
REQ-030 SHALL keep result_reg stable in DONE and IDLE; it is overwritten only at RUN completion.

Reset
REQ-031 SHALL, on rst: state IDLE; key_reg, data_reg, result_reg, kp, dp, rp, mode, irq_en, err, done, irq_pending all 0; interrupt 0.
REQ-032 SHALL abort immediately on rst asserted mid-RUN, leaving no start pulse pending after release.

Structure
REQ-033 SHALL take port offsets, ctrl/status bit positions and the FSM state enum from shared package xtea_port_pkg.
REQ-034 SHALL instantiate exactly one sub-module, xtea_core (start, decrypt, key, data_in, data_out, ready), fed by key_reg, data_reg and mode.

Verification
REQ-035 SHALL cover: 16 key writes 00..0F, 8 data writes 41..48, ctrl=0x01, poll status until 0x01, then 8 result reads -> ciphertext C; a second run with C loaded and ctrl=0x03 -> 8 reads return 41..48.
REQ-036 SHALL cover: ctrl=0x01 written twice back-to-back -> second ignored, status err bit (0x08) set, a status read clears it, exactly one start pulse observed.
REQ-037 SHALL cover: a data write during RUN -> data_reg unchanged, err set; a 9th data write in IDLE lands in byte 0 (wrap).
REQ-038 SHALL cover: ctrl=0x05 -> interrupt rises one cycle after ready; interrupt_ack in the same cycle as a next-run completion -> interrupt stays 1.
REQ-039 SHALL cover: rst pulsed mid-RUN -> status 0x00, in_port at +5 reads 00, no core start after release.
REQ-040 SHALL cover: write to +6 after 3 result reads -> next +5 read returns byte 0.

Source files
------------

// File: rtl/xtea_port_pkg.sv
// Shared definitions for the XTEA port-mapped responder.
// Holds the register offsets relative to the responder base port, the
// ctrl/status bit positions, the controller FSM state enum and the XTEA
// round constants used by the core.
package xtea_port_pkg;

  // Register offsets relative to PORT_BASE
  localparam logic [7:0] OFF_KEY     = 8'd0;
  localparam logic [7:0] OFF_DATA    = 8'd1;
  localparam logic [7:0] OFF_CTRL    = 8'd3;
  localparam logic [7:0] OFF_STATUS  = 8'd4;
  localparam logic [7:0] OFF_RESULT  = 8'd5;
  localparam logic [7:0] OFF_PTR_CLR = 8'd6;

  // ctrl register bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // status register bit positions
  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_IRQ  = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } xtea_state_e;

  // XTEA constants: 32 cycles, each cycle one full (two half) round
  localparam logic [31:0] XTEA_DELTA    = 32'h9E3779B9;
  localparam logic [31:0] XTEA_DEC_SUM  = 32'hC6EF3720;  // DELTA * 32 mod 2^32
  localparam logic [4:0]  XTEA_LAST_RND = 5'd31;

endpackage

// File: rtl/xtea_core.sv
// Iterative XTEA block cipher core, one full cycle (both Feistel halves)
// per clock, 32 clocks per block.
//   clk, rst  : clock, asynchronous active-high reset (control state only)
//   start     : one-cycle pulse; latches data_in and decrypt, begins a block
//   decrypt   : 0 encrypt, 1 decrypt
//   key       : 128-bit key, word i = key[32*i +: 32]; held stable while busy
//   data_in   : 64-bit block, v0 = [31:0], v1 = [63:32]
//   data_out  : {v1, v0}; valid when ready pulses and held afterwards
//   ready     : one-cycle pulse when the block is finished
module xtea_core
  import xtea_port_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] key,
  input  logic [63:0]  data_in,
  output logic [63:0]  data_out,
  output logic         ready
);

  logic        running;
  logic [4:0]  round_cnt;
  logic        dec_q;
  logic [31:0] v0, v1, sum;
  logic [31:0] v0_nxt, v1_nxt, sum_nxt;

  function automatic logic [31:0] mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  function automatic logic [31:0] key_word(input logic [127:0] k,
                                           input logic [1:0]   idx);
    return k[{idx, 5'b00000} +: 32];
  endfunction

  // One complete XTEA cycle; decrypt runs the halves in reverse order
  always_comb begin
    v0_nxt  = v0;
    v1_nxt  = v1;
    sum_nxt = sum;
    if (!dec_q) begin
      v0_nxt  = v0 + (mix(v1) ^ (sum + key_word(key, sum[1:0])));
      sum_nxt = sum + XTEA_DELTA;
      v1_nxt  = v1 + (mix(v0_nxt) ^ (sum_nxt + key_word(key, sum_nxt[12:11])));
    end else begin
      v1_nxt  = v1 - (mix(v0) ^ (sum + key_word(key, sum[12:11])));
      sum_nxt = sum - XTEA_DELTA;
      v0_nxt  = v0 - (mix(v1_nxt) ^ (sum_nxt + key_word(key, sum_nxt[1:0])));
    end
  end

  // Control: round counter and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      round_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        round_cnt <= '0;
      end else if (running) begin
        round_cnt <= round_cnt + 5'd1;
        if (round_cnt == XTEA_LAST_RND) begin
          running <= 1'b0;
          ready   <= 1'b1;
        end
      end
    end
  end

  // Datapath: block halves and running sum
  always_ff @(posedge clk) begin
    if (start) begin
      v0    <= data_in[31:0];
      v1    <= data_in[63:32];
      sum   <= decrypt ? XTEA_DEC_SUM : 32'd0;
      dec_q <= decrypt;
    end else if (running) begin
      v0  <= v0_nxt;
      v1  <= v1_nxt;
      sum <= sum_nxt;
    end
  end

  assign data_out = {v1, v0};

endmodule

// File: rtl/xtea_port_responder.sv
// Port-mapped XTEA peripheral for an 8-bit controller I/O bus.
// Key and data are loaded a byte at a time through auto-incrementing
// pointers, a ctrl write starts the core, and the 64-bit result is read
// back a byte at a time. Completion can raise a level interrupt.
//   clk, rst      : clock, asynchronous active-high reset
//   port_id       : controller port address
//   out_port      : controller write data
//   write_strobe  : one-cycle write qualifier
//   read_strobe   : one-cycle read qualifier (advances the result pointer,
//                   clears err on status reads)
//   in_port       : read data, combinational from port_id
//   interrupt     : completion interrupt level (irq_pending)
//   interrupt_ack : one-cycle acknowledge, clears irq_pending
module xtea_port_responder
  import xtea_port_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam logic [7:0] A_KEY     = PORT_BASE + OFF_KEY;
  localparam logic [7:0] A_DATA    = PORT_BASE + OFF_DATA;
  localparam logic [7:0] A_CTRL    = PORT_BASE + OFF_CTRL;
  localparam logic [7:0] A_STATUS  = PORT_BASE + OFF_STATUS;
  localparam logic [7:0] A_RESULT  = PORT_BASE + OFF_RESULT;
  localparam logic [7:0] A_PTR_CLR = PORT_BASE + OFF_PTR_CLR;

  xtea_state_e  state, state_nxt;
  logic [127:0] key_reg;
  logic [63:0]  data_reg, result_reg;
  logic [3:0]   kp;
  logic [2:0]   dp, rp;
  logic         mode, irq_en, err, done, irq_pending;

  logic         core_start, core_ready;
  logic [63:0]  core_data_out;

  logic wr_key, wr_data, wr_ctrl, wr_ptr_clr, rd_status, rd_result;
  logic busy, ctrl_ok, start_accept, finish, err_set, err_clr;
  logic [7:0] status_byte;

  assign wr_key     = write_strobe && (port_id == A_KEY);
  assign wr_data    = write_strobe && (port_id == A_DATA);
  assign wr_ctrl    = write_strobe && (port_id == A_CTRL);
  assign wr_ptr_clr = write_strobe && (port_id == A_PTR_CLR);
  assign rd_status  = read_strobe  && (port_id == A_STATUS);
  assign rd_result  = read_strobe  && (port_id == A_RESULT);

  assign busy         = (state == S_START) || (state == S_RUN);
  // With four states, "not busy" is exactly IDLE or DONE
  assign ctrl_ok      = wr_ctrl && !busy;
  assign start_accept = ctrl_ok && out_port[CTRL_START];
  assign finish       = (state == S_RUN) && core_ready;
  assign err_set      = busy && (wr_key || wr_data || (wr_ctrl && out_port[CTRL_START]));
  assign err_clr      = rd_status || wr_ptr_clr;

  // Controller FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_accept) state_nxt = S_START;
      S_START:        state_nxt = S_RUN;
      S_RUN:          if (core_ready) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // The core start pulse is the single START cycle, so a reset that
  // returns the FSM to IDLE cannot leave a start pending.
  assign core_start = (state == S_START);

  // Register file, pointers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg     <= '0;
      data_reg    <= '0;
      result_reg  <= '0;
      kp          <= '0;
      dp          <= '0;
      rp          <= '0;
      mode        <= 1'b0;
      irq_en      <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_key && !busy) begin
        key_reg[{kp, 3'b000} +: 8] <= out_port;
        kp <= kp + 4'd1;
      end
      if (wr_data && !busy) begin
        data_reg[{dp, 3'b000} +: 8] <= out_port;
        dp <= dp + 3'd1;
      end
      if (wr_ptr_clr) begin
        kp <= '0;
        dp <= '0;
      end

      if (ctrl_ok) begin
        mode   <= out_port[CTRL_MODE];
        irq_en <= out_port[CTRL_IRQ_EN];
      end

      if (start_accept || wr_ptr_clr) rp <= '0;
      else if (rd_result)             rp <= rp + 3'd1;

      // New events win over clears
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      if (start_accept) done <= 1'b0;
      else if (finish)  done <= 1'b1;

      if (finish && irq_en) irq_pending <= 1'b1;
      else if (interrupt_ack) irq_pending <= 1'b0;

      if (finish) result_reg <= core_data_out;
    end
  end

  always_comb begin
    status_byte            = 8'h00;
    status_byte[STAT_DONE] = done;
    status_byte[STAT_BUSY] = busy;
    status_byte[STAT_IRQ]  = irq_pending;
    status_byte[STAT_ERR]  = err;
  end

  always_comb begin
    in_port = 8'h00;
    if (port_id == A_STATUS)      in_port = status_byte;
    else if (port_id == A_RESULT) in_port = result_reg[{rp, 3'b000} +: 8];
  end

  assign interrupt = irq_pending;

  xtea_core u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (core_start),
    .decrypt  (mode),
    .key      (key_reg),
    .data_in  (data_reg),
    .data_out (core_data_out),
    .ready    (core_ready)
  );

endmodule

// File: tb/tb_xtea_port_responder.sv
// Scoreboard bench for xtea_port_responder: reads push their expected byte,
// a negedge monitor pops and compares while read_strobe is high.
module tb_xtea_port_responder;

  localparam logic [7:0] P_KEY  = 8'h30;
  localparam logic [7:0] P_DATA = 8'h31;
  localparam logic [7:0] P_UNM  = 8'h32;
  localparam logic [7:0] P_CTRL = 8'h33;
  localparam logic [7:0] P_STAT = 8'h34;
  localparam logic [7:0] P_RES  = 8'h35;
  localparam logic [7:0] P_CLR  = 8'h36;
  localparam logic [7:0] P_IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id = 8'hFF;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;

  xtea_port_responder #(.PORT_BASE(8'h30)) dut (
    .clk           (clk),
    .rst           (rst),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   poll_active = 1'b0;
  int   starts = 0;

  // Reference model state
  logic [127:0] m_key;
  logic [63:0]  m_data, m_res, m_next;
  int           m_kp, m_dp, m_rp;
  bit           m_err, m_done, m_irq, m_busy, m_mode, m_irqen;

  always @(negedge clk) if (dut.core_start === 1'b1) starts++;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (read_strobe && !poll_active) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: read at port %02h got %02h, no expected value", port_id, in_port);
      end else begin
        e = sb.pop_front();
        if (in_port !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %02h expected %02h", e.name, in_port, e.exp);
        end
      end
    end
  end

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [63:0] xtea_ref(input logic [127:0] key,
                                           input logic [63:0] blk, input bit dec);
    logic [31:0] y, z, sum, delta;
    logic [31:0] k [4];
    delta = 32'h9E3779B9;
    y = blk[31:0];
    z = blk[63:32];
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    if (!dec) begin
      sum = 32'd0;
      for (int r = 0; r < 32; r++) begin
        y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (sum + k[sum & 32'd3]));
        sum = sum + delta;
        z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (sum + k[(sum >> 11) & 32'd3]));
      end
    end else begin
      sum = delta * 32;
      for (int r = 0; r < 32; r++) begin
        z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (sum + k[(sum >> 11) & 32'd3]));
        sum = sum - delta;
        y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (sum + k[sum & 32'd3]));
      end
    end
    return {z, y};
  endfunction

  function automatic logic [7:0] status_exp();
    return {4'b0000, m_err, m_irq, m_busy, m_done};
  endfunction

  task automatic m_reset();
    m_key = '0; m_data = '0; m_res = '0; m_next = '0;
    m_kp = 0; m_dp = 0; m_rp = 0;
    m_err = 0; m_done = 0; m_irq = 0; m_busy = 0; m_mode = 0; m_irqen = 0;
  endtask

  // All bus tasks enter and leave just after a rising edge
  task automatic drive_wr(input logic [7:0] port, input logic [7:0] d);
    port_id = port; out_port = d; write_strobe = 1'b1;
    @(posedge clk); #1;
    write_strobe = 1'b0; port_id = P_IDLE;
  endtask

  task automatic wr_key(input logic [7:0] b);
    drive_wr(P_KEY, b);
    if (m_busy) m_err = 1;
    else begin m_key[8*m_kp +: 8] = b; m_kp = (m_kp + 1) % 16; end
  endtask

  task automatic wr_data(input logic [7:0] b);
    drive_wr(P_DATA, b);
    if (m_busy) m_err = 1;
    else begin m_data[8*m_dp +: 8] = b; m_dp = (m_dp + 1) % 8; end
  endtask

  task automatic wr_ctrl(input logic [7:0] c);
    drive_wr(P_CTRL, c);
    if (m_busy) begin
      if (c[0]) m_err = 1;
    end else begin
      m_mode = c[1]; m_irqen = c[2];
      if (c[0]) begin
        m_busy = 1; m_done = 0; m_rp = 0;
        m_next = xtea_ref(m_key, m_data, m_mode);
      end
    end
  endtask

  task automatic wr_clr();
    drive_wr(P_CLR, 8'h00);
    m_kp = 0; m_dp = 0; m_rp = 0; m_err = 0;
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] exp, input string name);
    exp_t e;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    port_id = port; read_strobe = 1'b1;
    @(posedge clk); #1;
    read_strobe = 1'b0; port_id = P_IDLE;
  endtask

  task automatic rd_status(input string name);
    rd(P_STAT, status_exp(), name);
    m_err = 0;
  endtask

  task automatic rd_result(input string name);
    rd(P_RES, m_res[8*m_rp +: 8], name);
    m_rp = (m_rp + 1) % 8;
  endtask

  task automatic read_all_results(input string tag);
    for (int i = 0; i < 8; i++) rd_result($sformatf("%s_res%0d", tag, i));
  endtask

  // Poll status (unchecked reads) until done, then retire the model run
  task automatic wait_done();
    logic [7:0] v;
    int n;
    v = 8'h00; n = 0;
    while (!v[0] && n < 200) begin
      poll_active = 1'b1; port_id = P_STAT; read_strobe = 1'b1;
      @(negedge clk); v = in_port;
      @(posedge clk); #1;
      read_strobe = 1'b0; poll_active = 1'b0; port_id = P_IDLE;
      n++;
    end
    m_err = 0;
    check("poll_done", {63'd0, v[0]}, 64'd1);
    m_busy = 0; m_done = 1; m_res = m_next;
    if (m_irqen) m_irq = 1;
  endtask

  task automatic wait_ready(output bit seen);
    int n;
    n = 0;
    while (dut.core_ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    seen = (dut.core_ready === 1'b1);
  endtask

  initial begin
    int snap;
    bit seen;
    logic [63:0] c_txt;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("irq_rst", {63'd0, interrupt}, 64'd0);
    rd_status("status_rst");
    rd(P_RES, 8'h00, "result_rst");
    rd(P_UNM, 8'h00, "unmapped_rd32");
    rd(8'h00, 8'h00, "unmapped_rd00");

    // Known-answer round trip
    for (int i = 0; i < 16; i++) wr_key(8'(i));
    for (int i = 0; i < 8; i++) wr_data(8'h41 + 8'(i));
    wr_ctrl(8'h01);
    wait_done();
    rd_status("status_done_enc");
    read_all_results("enc");
    c_txt = m_res;
    for (int i = 0; i < 8; i++) wr_data(c_txt[8*i +: 8]);
    wr_ctrl(8'h03);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      rd(P_RES, 8'h41 + 8'(i), $sformatf("dec_plain%0d", i));
      m_rp = (m_rp + 1) % 8;
    end

    // Double start
    snap = starts;
    wr_ctrl(8'h01);
    wr_ctrl(8'h01);
    rd_status("status_err_double_start");
    rd_status("status_err_cleared");
    wait_done();
    check("one_start_pulse", 64'(starts - snap), 64'd1);

    // Data write while running, then data pointer wrap
    wr_ctrl(8'h01);
    wr_data(8'hEE);
    check("data_unchanged_busy", dut.data_reg, m_data);
    rd_status("status_err_data_busy");
    wait_done();
    read_all_results("busy_run");
    for (int i = 0; i < 9; i++) wr_data(8'h10 + 8'(i));
    check("data_wrap", dut.data_reg, m_data);
    check("data_byte0_wrap", {56'd0, dut.data_reg[7:0]}, 64'h18);

    // Pointer clear after partial readout
    for (int i = 0; i < 3; i++) rd_result($sformatf("part_res%0d", i));
    wr_clr();
    rd_result("res_after_ptr_clr");

    // Interrupt timing and set-over-ack priority
    wr_ctrl(8'h05);
    wait_ready(seen);
    check("ready_seen1", {63'd0, seen}, 64'd1);
    check("irq_low_at_ready", {63'd0, interrupt}, 64'd0);
    @(negedge clk);
    check("irq_after_ready", {63'd0, interrupt}, 64'd1);
    @(posedge clk); #1;
    wait_done();
    rd_status("status_irq_done");
    wr_ctrl(8'h05);
    wait_ready(seen);
    check("ready_seen2", {63'd0, seen}, 64'd1);
    interrupt_ack = 1'b1;
    @(posedge clk); #1;
    interrupt_ack = 1'b0;
    check("irq_set_priority", {63'd0, interrupt}, 64'd1);
    wait_done();
    interrupt_ack = 1'b1;
    @(posedge clk); #1;
    interrupt_ack = 1'b0;
    m_irq = 0;
    check("irq_ack_clears", {63'd0, interrupt}, 64'd0);
    rd_status("status_after_ack");

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      wr_clr();
      for (int i = 0; i < 16; i++) wr_key(8'($urandom));
      for (int i = 0; i < 8; i++) wr_data(8'($urandom));
      drive_wr(P_UNM, 8'($urandom));
      rd(P_UNM, 8'h00, "unmapped_rd_rand");
      wr_ctrl({5'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1});
      wait_done();
      rd_status($sformatf("rand%0d_status", r));
      read_all_results($sformatf("rand%0d", r));
    end

    // Reset in the middle of a run
    wr_ctrl(8'h01);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    snap = starts;
    check("irq_after_rst", {63'd0, interrupt}, 64'd0);
    rd_status("status_after_rst");
    rd(P_RES, 8'h00, "result_after_rst");
    repeat (40) @(posedge clk);
    #1;
    check("no_start_after_rst", 64'(starts - snap), 64'd0);

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
